// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: controller states, default buffer
// address width and the SPI mode the shifter implements.
package spi_pkg;

  localparam int BUF_AW_DEF = 9;

  // {CPOL, CPHA}; mode 0 idles SCK low and samples on the rising edge.
  localparam logic [1:0] SPI_MODE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_STORE
  } state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period divider: while enabled, toggles SCK every i_div+1 cycles
// and flags the rising/falling edge one cycle ahead of the SCK register.
module spi_clkgen
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic       i_en,
  input  logic [7:0] i_div,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_sck
);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == i_div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_rise = w_tick & ~r_phase;
  assign o_fall = w_tick & r_phase;
  assign o_sck  = r_phase ^ SPI_MODE[1];

endmodule

// File: rtl/spi_master.sv
// Buffer-driven SPI master: reads each TX byte from the shared buffer, shifts
// it out full duplex on the selected device and writes the RX byte in place.
module spi_master
  import spi_pkg::*;
#(
  parameter int BUF_AW = BUF_AW_DEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [BUF_AW-1:0] Len,
  input  logic [7:0]        Div,
  input  logic              Dev,
  input  logic              CsAssert,
  output logic              Busy,
  output logic [BUF_AW-1:0] BufAddr,
  input  logic [7:0]        BufRdData,
  output logic [7:0]        BufWrData,
  output logic              BufWe,
  output logic              SPI_Cs,
  output logic              SPI_Clk,
  output logic              SPI_Do,
  input  logic              SPI_Di,
  output logic              TF_Cs,
  output logic              TF_Clk,
  output logic              TF_Do,
  input  logic              TF_Di
);

  state_t            r_state;
  state_t            w_next;
  logic [BUF_AW-1:0] r_addr;
  logic [BUF_AW-1:0] r_len;
  logic [7:0]        r_div;
  logic              r_dev;
  logic [7:0]        r_tx;
  logic [7:0]        r_rx;
  logic [2:0]        r_bit;
  logic              r_fetch_wait;

  logic w_shifting;
  logic w_rise;
  logic w_fall;
  logic w_sck;
  logic w_mosi;
  logic w_miso;

  assign w_shifting = (r_state == ST_SHIFT);

  spi_clkgen u_clkgen (
    .clk    (clk),
    .nReset (nReset),
    .i_en   (w_shifting),
    .i_div  (r_div),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_sck  (w_sck)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    Busy   = (r_state != ST_IDLE);
    BufWe  = 1'b0;
    case (r_state)
      ST_IDLE:  if (Start) w_next = ST_FETCH;
      ST_FETCH: if (r_fetch_wait) w_next = ST_SHIFT;
      ST_SHIFT: if (w_fall && (r_bit == 3'd7)) w_next = ST_STORE;
      ST_STORE: begin
        BufWe  = 1'b1;
        w_next = (r_addr == r_len) ? ST_IDLE : ST_FETCH;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // The first FETCH cycle presents the address; BufRdData is valid in the second.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_div        <= '0;
      r_dev        <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_bit        <= '0;
      r_fetch_wait <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_addr       <= '0;
            r_len        <= Len;
            r_div        <= Div;
            r_dev        <= Dev;
            r_fetch_wait <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_fetch_wait <= 1'b1;
          if (r_fetch_wait) begin
            r_tx         <= BufRdData;
            r_bit        <= '0;
            r_fetch_wait <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_rise) r_rx <= {r_rx[6:0], w_miso};
          if (w_fall) begin
            r_tx  <= {r_tx[6:0], 1'b0};
            r_bit <= r_bit + 3'd1;
          end
        end
        ST_STORE: begin
          if (r_addr != r_len) r_addr <= r_addr + BUF_AW'(1);
          r_fetch_wait <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign BufAddr   = r_addr;
  assign BufWrData = r_rx;

  assign w_mosi = w_shifting & r_tx[7];
  assign w_miso = r_dev ? TF_Di : SPI_Di;

  // Chip selects follow CsAssert combinationally; reset forces both inactive.
  assign SPI_Cs  = ~(nReset & CsAssert & ~r_dev);
  assign SPI_Clk = ~r_dev & w_sck;
  assign SPI_Do  = ~r_dev & w_mosi;
  assign TF_Cs   = ~(nReset & CsAssert & r_dev);
  assign TF_Clk  = r_dev & w_sck;
  assign TF_Do   = r_dev & w_mosi;

endmodule
